// File: rtl/f_align_shift.sv
// Operand swap and significand alignment for the single-precision adder.
// Stage 1 routes the larger-exponent operand to the big path; stage 2 right-shifts the small significand and folds the shifted-out bits into sticky.
module f_align_shift #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int SAT_SH = 26
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 alessb,
    input  logic [EXP_W:0]       exp_diff,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MAN_W+3:0]     big_sig,
    output logic [MAN_W+3:0]     small_sig,
    output logic [EXP_W-1:0]     res_exp,
    output logic                 big_sign,
    output logic                 eff_sub,
    output logic                 swapped
);

    localparam int OP_W  = EXP_W + MAN_W + 1;
    localparam int SIG_W = MAN_W + 1;
    localparam int EXT_W = MAN_W + 4;
    localparam int SH_W  = EXP_W + 1;
    localparam logic [SH_W-1:0] SAT_AMT = SH_W'(SAT_SH);

    logic               advance;

    logic [OP_W-1:0]    l_op;
    logic [OP_W-1:0]    s_op;
    logic [EXP_W-1:0]   l_exp;
    logic [EXP_W-1:0]   s_exp;
    logic [SH_W-1:0]    sh_in;

    logic               s1_valid_q, s1_valid_d;
    logic               s1_sign_q, s1_sign_d;
    logic [EXP_W-1:0]   s1_exp_q, s1_exp_d;
    logic [SIG_W-1:0]   s1_lsig_q, s1_lsig_d;
    logic [SIG_W-1:0]   s1_ssig_q, s1_ssig_d;
    logic [SH_W-1:0]    s1_sh_q, s1_sh_d;
    logic               s1_eff_sub_q, s1_eff_sub_d;
    logic               s1_swap_q, s1_swap_d;

    logic [EXT_W-1:0]   ext_sig;
    logic [EXT_W-1:0]   shifted;
    logic [EXT_W-1:0]   lost_mask;
    logic               sticky;
    logic [EXT_W-1:0]   aligned;

    logic               out_valid_q, out_valid_d;
    logic [EXT_W-1:0]   big_sig_q, big_sig_d;
    logic [EXT_W-1:0]   small_sig_q, small_sig_d;
    logic [EXP_W-1:0]   res_exp_q, res_exp_d;
    logic               big_sign_q, big_sign_d;
    logic               eff_sub_q, eff_sub_d;
    logic               swapped_q, swapped_d;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || advance;

    // Swap and subnormal shift correction
    always_comb begin
        l_op  = alessb ? b : a;
        s_op  = alessb ? a : b;
        l_exp = l_op[OP_W-2:MAN_W];
        s_exp = s_op[OP_W-2:MAN_W];
        // A subnormal small operand has effective exponent 1, so it sits one place closer.
        if ((s_exp == '0) && (l_exp != '0) && (exp_diff != '0)) begin
            sh_in = exp_diff - SH_W'(1);
        end else begin
            sh_in = exp_diff;
        end
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sign_d    = s1_sign_q;
        s1_exp_d     = s1_exp_q;
        s1_lsig_d    = s1_lsig_q;
        s1_ssig_d    = s1_ssig_q;
        s1_sh_d      = s1_sh_q;
        s1_eff_sub_d = s1_eff_sub_q;
        s1_swap_d    = s1_swap_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d    = l_op[OP_W-1];
                s1_exp_d     = (l_exp == '0) ? EXP_W'(1) : l_exp;
                s1_lsig_d    = {(l_exp != '0), l_op[MAN_W-1:0]};
                s1_ssig_d    = {(s_exp != '0), s_op[MAN_W-1:0]};
                s1_sh_d      = sh_in;
                s1_eff_sub_d = a[OP_W-1] ^ b[OP_W-1];
                s1_swap_d    = alessb;
            end
        end
    end

    // Alignment shift with sticky collection
    always_comb begin
        ext_sig   = {s1_ssig_q, 3'b000};
        shifted   = ext_sig >> s1_sh_q;
        lost_mask = ~({EXT_W{1'b1}} << s1_sh_q);
        sticky    = |(ext_sig & lost_mask);
        if (s1_sh_q >= SAT_AMT) begin
            aligned = {{(EXT_W-1){1'b0}}, |s1_ssig_q};
        end else begin
            aligned = {shifted[EXT_W-1:1], shifted[0] | sticky};
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        big_sig_d   = big_sig_q;
        small_sig_d = small_sig_q;
        res_exp_d   = res_exp_q;
        big_sign_d  = big_sign_q;
        eff_sub_d   = eff_sub_q;
        swapped_d   = swapped_q;
        if (advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                big_sig_d   = {s1_lsig_q, 3'b000};
                small_sig_d = aligned;
                res_exp_d   = s1_exp_q;
                big_sign_d  = s1_sign_q;
                eff_sub_d   = s1_eff_sub_q;
                swapped_d   = s1_swap_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_lsig_q    <= '0;
            s1_ssig_q    <= '0;
            s1_sh_q      <= '0;
            s1_eff_sub_q <= 1'b0;
            s1_swap_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            big_sig_q    <= '0;
            small_sig_q  <= '0;
            res_exp_q    <= '0;
            big_sign_q   <= 1'b0;
            eff_sub_q    <= 1'b0;
            swapped_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_exp_q     <= s1_exp_d;
            s1_lsig_q    <= s1_lsig_d;
            s1_ssig_q    <= s1_ssig_d;
            s1_sh_q      <= s1_sh_d;
            s1_eff_sub_q <= s1_eff_sub_d;
            s1_swap_q    <= s1_swap_d;
            out_valid_q  <= out_valid_d;
            big_sig_q    <= big_sig_d;
            small_sig_q  <= small_sig_d;
            res_exp_q    <= res_exp_d;
            big_sign_q   <= big_sign_d;
            eff_sub_q    <= eff_sub_d;
            swapped_q    <= swapped_d;
        end
    end

    assign out_valid = out_valid_q;
    assign big_sig   = big_sig_q;
    assign small_sig = small_sig_q;
    assign res_exp   = res_exp_q;
    assign big_sign  = big_sign_q;
    assign eff_sub   = eff_sub_q;
    assign swapped   = swapped_q;

endmodule

// File: tb/tb_f_align_shift.sv
// Directed scoreboard bench for f_align_shift: the driver queues hand-computed results,
// a negedge monitor compares every presented output against the queue head.
module tb_f_align_shift;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        alessb;
    logic [8:0]  exp_diff;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] big_sig;
    logic [26:0] small_sig;
    logic [7:0]  res_exp;
    logic        big_sign;
    logic        eff_sub;
    logic        swapped;

    typedef struct {
        logic [26:0] big_sig;
        logic [26:0] small_sig;
        logic [7:0]  res_exp;
        logic        big_sign;
        logic        eff_sub;
        logic        swapped;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    f_align_shift dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alessb    (alessb),
        .exp_diff  (exp_diff),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .big_sig   (big_sig),
        .small_sig (small_sig),
        .res_exp   (res_exp),
        .big_sign  (big_sign),
        .eff_sub   (eff_sub),
        .swapped   (swapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic [26:0] bs, input logic [26:0] ss, input logic [7:0] re,
                                input logic sg, input logic es, input logic sw);
        exp_t e;
        e.big_sig = bs; e.small_sig = ss; e.res_exp = re;
        e.big_sign = sg; e.eff_sub = es; e.swapped = sw;
        return e;
    endfunction

    // Drives one bundle; returns at posedge+1 of its handshake edge.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_op, input logic [8:0] d,
                        input logic al, input exp_t e);
        logic ok;
        a = ta; b = tb_op; exp_diff = d; alessb = al; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (ok) sb.push_back(e);
        else chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                chk("big_sig",   {5'd0, big_sig},   {5'd0, sb[0].big_sig});
                chk("small_sig", {5'd0, small_sig}, {5'd0, sb[0].small_sig});
                chk("res_exp",   {24'd0, res_exp},  {24'd0, sb[0].res_exp});
                chk("big_sign",  {31'd0, big_sign}, {31'd0, sb[0].big_sign});
                chk("eff_sub",   {31'd0, eff_sub},  {31'd0, sb[0].eff_sub});
                chk("swapped",   {31'd0, swapped},  {31'd0, sb[0].swapped});
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    exp_t e1, e2, e3, e4, e5, e6, e7, e8, e9;

    initial begin
        int n;
        e1 = mk(27'h6000000, 27'h2000000, 8'h80, 1'b0, 1'b0, 1'b0);
        e2 = mk(27'h4000000, 27'h0400001, 8'h83, 1'b0, 1'b0, 1'b1);
        e3 = mk(27'h4000000, 27'h0000001, 8'h9D, 1'b0, 1'b0, 1'b1);
        e4 = mk(27'h4000000, 27'h0000018, 8'h01, 1'b0, 1'b1, 1'b0);
        e5 = mk(27'h4000000, 27'h0000002, 8'h98, 1'b0, 1'b0, 1'b0); // shift 25
        e6 = mk(27'h4000000, 27'h0000001, 8'h99, 1'b0, 1'b0, 1'b0); // shift 26 saturates
        e7 = mk(27'h6000000, 27'h2000000, 8'h80, 1'b1, 1'b1, 1'b0);
        e8 = mk(27'h6000000, 27'h4000000, 8'h7F, 1'b0, 1'b0, 1'b0); // equal exponents
        e9 = mk(27'h0000028, 27'h0000010, 8'h01, 1'b0, 1'b0, 1'b0); // both subnormal

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; alessb = 1'b0; exp_diff = '0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_big_sig",   {5'd0, big_sig},    32'd0);
        chk("rst_small_sig", {5'd0, small_sig},  32'd0);
        chk("rst_res_exp",   {24'd0, res_exp},   32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        send(32'h40400000, 32'h3F800000, 9'd1, 1'b0, e1);
        n = 0;
        for (int i = 0; i < 10 && !out_valid; i++) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 32'd2);
        @(posedge clk); #1;

        send(32'h3F800001, 32'h41800000, 9'd4,  1'b1, e2);
        send(32'h3F800000, 32'h4E800000, 9'd30, 1'b1, e3);
        send(32'h00800000, 32'h80000003, 9'd1,  1'b0, e4);
        send(32'h4C000000, 32'h3F800000, 9'd25, 1'b0, e5);
        send(32'h4C800000, 32'h3F800000, 9'd26, 1'b0, e6);
        send(32'hC0400000, 32'h3F800000, 9'd1,  1'b0, e7);
        send(32'h3FC00000, 32'h3F800000, 9'd0,  1'b0, e8);
        send(32'h00000005, 32'h00000002, 9'd0,  1'b0, e9);
        repeat (4) @(posedge clk);
        #1;

        // Stream four bundles while the output is stalled.
        out_ready = 1'b0;
        fork
            begin
                send(32'h40400000, 32'h3F800000, 9'd1,  1'b0, e1);
                send(32'h3F800001, 32'h41800000, 9'd4,  1'b1, e2);
                send(32'h3F800000, 32'h4E800000, 9'd30, 1'b1, e3);
                send(32'h00800000, 32'h80000003, 9'd1,  1'b0, e4);
            end
            begin
                for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
                chk("stream_first_valid", {31'd0, out_valid}, 32'd1);
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("stream_drain", sb.size(), 32'd0);

        // Reset with two bundles in flight.
        out_ready = 1'b0;
        send(32'h40400000, 32'h3F800000, 9'd1, 1'b0, e1);
        send(32'h3F800001, 32'h41800000, 9'd4, 1'b1, e2);
        #1 rst_n = 1'b0;
        #1;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
        chk("flush_big_sig",   {5'd0, big_sig},    32'd0);
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        send(32'h3F800000, 32'h4E800000, 9'd30, 1'b1, e3);
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("final_drain", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
